// File: rtl/pitch_glide_if.sv
// Sequencer-to-oscillator tuning bus.
// Master drives note controls, slave returns tuning.
interface pitch_glide_if #(
    parameter int WIDTH    = 18,
    parameter int OCT_BITS = 2
);
    logic [3:0]          pitch;
    logic [OCT_BITS-1:0] octave;
    logic                glide_en;
    logic                glide_tick;
    logic [WIDTH-1:0]    tuning_increment;
    logic                gate;
    logic                settled;

    modport master (
        output pitch,
        output octave,
        output glide_en,
        output glide_tick,
        input  tuning_increment,
        input  gate,
        input  settled
    );

    modport slave (
        input  pitch,
        input  octave,
        input  glide_en,
        input  glide_tick,
        output tuning_increment,
        output gate,
        output settled
    );
endinterface

// File: rtl/pitch_glide.sv
// Note index + octave to oscillator tuning value,
// with optional tick-paced portamento toward the target.
module pitch_glide #(
    parameter int WIDTH       = 18,
    parameter int OCT_BITS    = 2,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic          clk,
    input  logic          rst,
    pitch_glide_if.slave  bus
);
    function automatic logic [15:0] base_of(
        input logic [3:0] p
    );
        case (p)
            4'd1:    base_of = 16'd30578;
            4'd2:    base_of = 16'd27242;
            4'd3:    base_of = 16'd24270;
            4'd4:    base_of = 16'd22908;
            4'd5:    base_of = 16'd20408;
            4'd6:    base_of = 16'd18182;
            4'd7:    base_of = 16'd16198;
            4'd8:    base_of = 16'd15289;
            4'd9:    base_of = 16'd13621;
            4'd10:   base_of = 16'd12135;
            4'd11:   base_of = 16'd11454;
            4'd12:   base_of = 16'd10204;
            4'd13:   base_of = 16'd9091;
            4'd14:   base_of = 16'd8099;
            4'd15:   base_of = 16'd7645;
            default: base_of = 16'd0;
        endcase
    endfunction

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] tuning;
    logic             note_s1;
    logic             glide_s1;
    logic             gate_q;
    logic             had_note;

    logic [WIDTH-1:0] base_w;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] step_raw;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] glided;

    assign base_w  = WIDTH'(base_of(bus.pitch));
    assign shifted = base_w >> bus.octave;

    // Signed distance to target and a clamped slew step.
    always_comb begin
        diff = {1'b0, target} - {1'b0, tuning};
        if (diff[WIDTH])
            mag = (~diff[WIDTH-1:0]) + 1'b1;
        else
            mag = diff[WIDTH-1:0];
        step_raw = mag >> GLIDE_SHIFT;
        step = step_raw;
        if (step_raw == '0)
            step = WIDTH'(1);
        if (step > mag)
            step = mag;
        if (diff[WIDTH])
            glided = tuning - step;
        else
            glided = tuning + step;
    end

    // Stage 1: latch target on notes; rests keep the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            target   <= '0;
            note_s1  <= 1'b0;
            glide_s1 <= 1'b0;
        end else begin
            if (bus.pitch != 4'd0)
                target <= shifted;
            note_s1  <= (bus.pitch != 4'd0);
            glide_s1 <= bus.glide_en;
        end
    end

    // Stage 2: gate, jump or slew; rests hold the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            tuning   <= '0;
            gate_q   <= 1'b0;
            had_note <= 1'b0;
        end else begin
            gate_q <= note_s1;
            if (!note_s1) begin
                had_note <= 1'b0;
            end else if (!glide_s1 || !had_note) begin
                tuning   <= target;
                had_note <= 1'b1;
            end else if (bus.glide_tick) begin
                tuning <= glided;
            end
        end
    end

    assign bus.tuning_increment = tuning;
    assign bus.gate             = gate_q;
    assign bus.settled          = (tuning == target);
endmodule

// File: tb/tb_pitch_glide.sv
// Bench for pitch_glide: table vectors, glide
// sequences and randomized run against a model.
module tb_pitch_glide;
    localparam int W = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pitch_glide_if #(.WIDTH(W), .OCT_BITS(2)) bus ();

    pitch_glide #(
        .WIDTH(W),
        .OCT_BITS(2),
        .GLIDE_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    int base_tab [16] = '{0,
        30578, 27242, 24270, 22908, 20408, 18182, 16198,
        15289, 13621, 12135, 11454, 10204, 9091, 8099,
        7645};

    // Behavioural model: what the outputs must be
    // after each edge, in plain integers.
    int m_tgt, m_cur, m_had, m_gate;
    int p_note, p_glide;

    task automatic model_edge();
        int d, mag, st;
        if (rst) begin
            m_tgt = 0; m_cur = 0; m_had = 0;
            m_gate = 0; p_note = 0; p_glide = 0;
        end else begin
            m_gate = p_note;
            if (p_note == 0) begin
                m_had = 0;
            end else if (p_glide == 0 || m_had == 0) begin
                m_cur = m_tgt;
                m_had = 1;
            end else if (bus.glide_tick) begin
                d = m_tgt - m_cur;
                mag = (d < 0) ? -d : d;
                st = mag / 16;
                if (st < 1) st = 1;
                if (st > mag) st = mag;
                m_cur = m_cur + ((d < 0) ? -st : st);
            end
            if (bus.pitch != 0)
                m_tgt = base_tab[bus.pitch] >> bus.octave;
            p_note = (bus.pitch != 0);
            p_glide = int'(bus.glide_en);
        end
    endtask

    task automatic check(input string nm,
                         input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d want %0d",
                     nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input int p,
                         input int o, input bit g,
                         input bit t);
        rst            = r;
        bus.pitch      = 4'(p);
        bus.octave     = 2'(o);
        bus.glide_en   = g;
        bus.glide_tick = t;
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string nm);
        check({nm, "_tun"},
              int'(bus.tuning_increment), m_cur);
        check({nm, "_gate"}, int'(bus.gate), m_gate);
        check({nm, "_set"}, int'(bus.settled),
              int'(m_cur == m_tgt));
    endtask

    typedef struct {
        int p;
        int o;
        int exp;
    } vec_t;

    vec_t vt [$];

    initial begin
        int prev, tun, n;
        bit done;

        drive(1, 7, 3, 1, 1);
        tick_clk();
        drive(1, 2, 1, 0, 1);
        tick_clk();
        check("rst_tun", int'(bus.tuning_increment), 0);
        check("rst_gate", int'(bus.gate), 0);
        check("rst_set", int'(bus.settled), 1);

        vt.push_back('{1, 0, 30578});
        vt.push_back('{2, 0, 27242});
        vt.push_back('{3, 0, 24270});
        vt.push_back('{4, 0, 22908});
        vt.push_back('{5, 0, 20408});
        vt.push_back('{6, 0, 18182});
        vt.push_back('{7, 0, 16198});
        vt.push_back('{8, 0, 15289});
        vt.push_back('{9, 0, 13621});
        vt.push_back('{10, 0, 12135});
        vt.push_back('{11, 0, 11454});
        vt.push_back('{12, 0, 10204});
        vt.push_back('{13, 0, 9091});
        vt.push_back('{14, 0, 8099});
        vt.push_back('{15, 0, 7645});
        vt.push_back('{1, 2, 7644});
        vt.push_back('{8, 1, 7644});
        vt.push_back('{15, 3, 955});
        vt.push_back('{2, 3, 3405});

        // Exact 2-clock latency, then table value.
        drive(0, 0, 0, 0, 0);
        tick_clk();
        tick_clk();
        foreach (vt[i]) begin
            drive(0, vt[i].p, vt[i].o, 0, 0);
            tick_clk();
            drive(0, vt[i].p, vt[i].o, 0, 0);
            tick_clk();
            check("table", int'(bus.tuning_increment),
                  vt[i].exp);
            check("tab_gate", int'(bus.gate), 1);
            check("tab_set", int'(bus.settled), 1);
        end

        // Glide 30578 -> 15289.
        drive(0, 1, 0, 0, 0);
        repeat (3) tick_clk();
        check("g_start", int'(bus.tuning_increment), 30578);
        drive(0, 8, 0, 1, 0);
        tick_clk();
        tick_clk();
        check("g_hold", int'(bus.tuning_increment), 30578);
        check("g_unset", int'(bus.settled), 0);
        drive(0, 8, 0, 1, 1);
        tick_clk();
        drive(0, 8, 0, 1, 0);
        check("g_step1", int'(bus.tuning_increment), 29623);
        check("g_set0", int'(bus.settled), 0);
        tick_clk();
        check("g_notick", int'(bus.tuning_increment), 29623);
        prev = 29623;
        done = 0;
        n = 0;
        while (!done && n < 400) begin
            drive(0, 8, 0, 1, 1);
            tick_clk();
            tun = int'(bus.tuning_increment);
            if (tun >= prev || tun < 15289)
                check("g_mono", tun, prev - 1);
            prev = tun;
            n++;
            if (bus.settled) done = 1;
        end
        check("g_done", int'(done), 1);
        check("g_end", int'(bus.tuning_increment), 15289);
        drive(0, 8, 0, 1, 1);
        tick_clk();
        check("g_idle", int'(bus.tuning_increment), 15289);

        // Rest holds tail, next note jumps.
        drive(0, 0, 0, 1, 0);
        tick_clk();
        tick_clk();
        check("r_gate", int'(bus.gate), 0);
        check("r_hold", int'(bus.tuning_increment), 15289);
        drive(0, 1, 0, 1, 1);
        tick_clk();
        tick_clk();
        check("r_jump", int'(bus.tuning_increment), 30578);
        check("r_gate1", int'(bus.gate), 1);

        // Toggle 1<->15, tick every cycle, rst mid.
        for (int i = 0; i < 300; i++) begin
            drive(i == 150, ((i / 7) % 2) ? 15 : 1,
                  0, 1, 1);
            tick_clk();
            check_model("tog");
            tun = int'(bus.tuning_increment);
            if (tun != 0 && (tun < 7645 || tun > 30578))
                check("tog_rng", tun, 7645);
            if (i == 150)
                check("tog_rst", tun, 0);
        end

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 5) == 0) ? 0 :
                      int'($urandom_range(1, 15)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1));
            if (i % 11 != 0) begin
                bus.pitch  = 4'(p_note ? bus.pitch : 0);
            end
            tick_clk();
            check_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end
endmodule
